add_pipe: RTL and testbench
===========================

ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (2..64).
REQ-002 Parameter STAGES, default 2, accept-to-result latency in cycles (1..4).
REQ-003 Parameter SATURATE, default 0, 1 = clamp signed overflow to max/min.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 in_op  input  2  operation code (see REQ-012).
REQ-009 a, b  input  WIDTH each  operands.
REQ-010 out_valid  output  1  result beat present; out_ready  input  1  sink accepts.
REQ-011 out, out_carry, out_ovf  output  WIDTH, 1, 1  result, unsigned carry/borrow, signed overflow.

Function
REQ-012 Ops: ADD r=a+b; SUB r=a-b; ACC r=acc+a (b ignored), acc<=r; CLR r=0, acc<=0, flags 0.
REQ-013 Beat accepted when in_valid && in_ready; no other cycle changes acc or pipeline contents.
REQ-014 Result computed in stage 1 from accepted beat; stages 2..STAGES are pure delay.
REQ-015 Global advance = !out_valid || out_ready; in_ready = advance; all stages hold when advance=0.
REQ-016 Latency: beat accepted at cycle N -> out_valid at N+STAGES if never stalled; each stall cycle adds one.
REQ-017 Throughput: one beat per cycle when out_ready held high; no bubbles inserted.
REQ-018 Empty stages (bubbles) advance freely and are discarded; out_valid reflects last stage valid bit only.
REQ-019 out, out_carry, out_ovf stable while out_valid=1 and out_ready=0.
REQ-020 out_carry: ADD/ACC = carry out of bit WIDTH-1; SUB = borrow (a<b unsigned).
REQ-021 out_ovf: signed overflow of the WIDTH-bit two's-complement operation.
REQ-022 SATURATE=1 and out_ovf=1: out = 2^(WIDTH-1)-1 if true result positive, else -2^(WIDTH-1); flags still reported; acc stores clamped value.
REQ-023 SATURATE=0: result wraps modulo 2^WIDTH; acc stores wrapped value.
REQ-024 Back-to-back ACC beats: second beat uses acc updated by first (no hazard; acc updates at acceptance).
REQ-025 Simultaneous accept and output handshake in same cycle is legal and loses no beat.

Reset
REQ-026 rst_n=0 at posedge clk: all stage valid bits 0, acc 0, out 0, out_carry 0, out_ovf 0.
REQ-027 During reset in_ready=0; first accept possible on first posedge with rst_n=1.
REQ-028 Reset mid-operation discards all in-flight beats; no partial result emitted afterwards.

Structure
REQ-029 Package add_pipe_pkg holds op enum (OP_ADD=0, OP_SUB=1, OP_ACC=2, OP_CLR=3) and result struct {data, carry, ovf} typedef parameterised via WIDTH-sized field in the module.
REQ-030 One sub-module add_pipe_stage: enable-gated register of valid + payload, instantiated STAGES-1 times via generate.
REQ-031 Compute stage and acc register live in add_pipe top.

Verification
REQ-032 WIDTH=32, STAGES=2: ADD a=5,b=0..99 one per cycle, out_ready=1 -> out=5..104, each 2 cycles after accept, no gaps.
REQ-033 SUB a=3,b=5 -> out=0xFFFFFFFE, out_carry=1, out_ovf=0; ADD a=0x7FFFFFFF,b=1 -> out=0x80000000, out_ovf=1.
REQ-034 SATURATE=1: ADD 0x7FFFFFFF+1 -> out=0x7FFFFFFF, out_ovf=1; SUB 0x80000000-1 -> out=0x80000000, out_ovf=1.
REQ-035 CLR then ACC a=10,20,30 back-to-back -> out=10,30,60; CLR -> out=0.
REQ-036 out_ready low 3 cycles with pipeline full -> in_ready=0, out held stable, no beat lost or duplicated (scoreboard).
REQ-037 rst_n low one cycle with 2 beats in flight -> out_valid=0 next cycle, acc=0, neither beat ever emitted.

Source files
------------

// File: rtl/add_pipe_pkg.sv
// Shared types for the add_pipe arithmetic pipeline.
// Holds the operation encoding used on in_op.
package add_pipe_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_ACC = 2'd2,
      OP_CLR = 2'd3
   } op_e;

   // carry + ovf bits appended to the data field of a result
   localparam int FLAG_BITS = 2;

endpackage

// File: rtl/add_pipe_stage.sv
// One delay stage: enable-gated register of valid + payload.
// Ports: clk, rst_n, en, in_valid/in_data -> out_valid/out_data.
module add_pipe_stage #(
   parameter int PW = 34
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          in_valid,
   input  logic [PW-1:0] in_data,
   output logic          out_valid,
   output logic [PW-1:0] out_data
);

   // Payload only loads with a valid beat so bubbles never disturb it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         if (in_valid)
            out_data <= in_data;
      end
   end

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/sub/accumulate unit with valid/ready flow control.
// Ports: clk, rst_n, in_valid/in_ready/in_op/a/b, out_valid/out_ready/out/out_carry/out_ovf.
module add_pipe
   import add_pipe_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int STAGES   = 2,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_carry,
   output logic             out_ovf
);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             carry;
      logic             ovf;
   } res_t;

   localparam int PW = WIDTH + FLAG_BITS;
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   op_e              op;
   logic             adv;
   logic             fire;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             sub;
   logic [WIDTH:0]   sum;
   logic             ovf;
   res_t             r;

   logic             s1_valid;
   logic [PW-1:0]    s1_data;
   logic             vv [STAGES];
   logic [PW-1:0]    dd [STAGES];
   res_t             o;

   assign op       = op_e'(in_op);
   assign adv      = !out_valid || out_ready;
   assign in_ready = rst_n && adv;
   assign fire     = in_valid && in_ready;

   always_comb begin
      x   = a;
      y   = b;
      sub = 1'b0;
      unique case (op)
         OP_ADD: ;
         OP_SUB: sub = 1'b1;
         OP_ACC: begin
            x = acc;
            y = a;
         end
         OP_CLR: ;
         default: ;
      endcase

      // bit WIDTH is carry for add, borrow (x<y) for sub
      if (sub)
         sum = {1'b0, x} - {1'b0, y};
      else
         sum = {1'b0, x} + {1'b0, y};

      if (sub)
         ovf = (x[WIDTH-1] != y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      else
         ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

      r.data  = sum[WIDTH-1:0];
      r.carry = sum[WIDTH];
      r.ovf   = ovf;

      // On overflow the true result has the sign of the first operand.
      if ((SATURATE != 0) && ovf)
         r.data = x[WIDTH-1] ? SMIN : SMAX;

      if (op == OP_CLR)
         r = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         acc      <= '0;
      end else begin
         if (adv) begin
            s1_valid <= fire;
            if (fire)
               s1_data <= r;
         end
         if (fire && op == OP_ACC)
            acc <= r.data;
         else if (fire && op == OP_CLR)
            acc <= '0;
      end
   end

   assign vv[0] = s1_valid;
   assign dd[0] = s1_data;

   for (genvar i = 1; i < STAGES; i++) begin : g_dly
      add_pipe_stage #(
         .PW(PW)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (adv),
         .in_valid (vv[i-1]),
         .in_data  (dd[i-1]),
         .out_valid(vv[i]),
         .out_data (dd[i])
      );
   end

   assign o         = res_t'(dd[STAGES-1]);
   assign out_valid = vv[STAGES-1];
   assign out       = o.data;
   assign out_carry = o.carry;
   assign out_ovf   = o.ovf;

endmodule

// File: tb/tb_add_pipe.sv
// Directed testbench for add_pipe (wrapping and saturating instances).
// Both instances share stimulus; each task checks its own scenario.
module tb_add_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [1:0]  in_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_ready;

   logic        in_ready,  s_in_ready;
   logic        out_valid, s_out_valid;
   logic [31:0] out,       s_out;
   logic        out_carry, s_out_carry;
   logic        out_ovf,   s_out_ovf;

   int n_chk;
   int n_fail;

   add_pipe #(.WIDTH(32), .STAGES(2), .SATURATE(0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out      (out),
      .out_carry(out_carry),
      .out_ovf  (out_ovf)
   );

   add_pipe #(.WIDTH(32), .STAGES(2), .SATURATE(1)) dut_s (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (s_in_ready),
      .in_op    (in_op),
      .a        (a),
      .b        (b),
      .out_valid(s_out_valid),
      .out_ready(out_ready),
      .out      (s_out),
      .out_carry(s_out_carry),
      .out_ovf  (s_out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [1:0] ADD = 2'd0;
   localparam logic [1:0] SUB = 2'd1;
   localparam logic [1:0] ACC = 2'd2;
   localparam logic [1:0] CLR = 2'd3;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat, then waits (bounded) for it to reach the output.
   task automatic send_one(input logic [1:0] op, input logic [31:0] aa,
                           input logic [31:0] bb, output logic got,
                           output logic [33:0] rn, output logic [33:0] rs);
      in_op    = op;
      a        = aa;
      b        = bb;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      got = 1'b0;
      rn  = '0;
      rs  = '0;
      for (int k = 0; k < 10 && !got; k++) begin
         if (out_valid) begin
            got = 1'b1;
            rn  = {out, out_carry, out_ovf};
            rs  = {s_out, s_out_carry, s_out_ovf};
         end else begin
            cyc();
         end
      end
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) cyc();
   endtask

   task automatic test_reset();
      n_chk++;
      if (in_ready !== 1'b0 || s_in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready got %b/%b exp 0", in_ready, s_in_ready);
      end
      n_chk++;
      if ({out_valid, out, out_carry, out_ovf} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got v=%b out=%h c=%b o=%b exp all 0",
                  out_valid, out, out_carry, out_ovf);
      end
      n_chk++;
      if ({s_out_valid, s_out, s_out_carry, s_out_ovf} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_outputs_sat got v=%b out=%h exp all 0",
                  s_out_valid, s_out);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset got %b exp 1", in_ready);
      end
      repeat (2) cyc();
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL no_beat_during_reset got out_valid=%b exp 0", out_valid);
      end
   endtask

   task automatic test_stream();
      logic [31:0] e;
      drain();
      in_op     = ADD;
      a         = 32'd5;
      out_ready = 1'b1;
      for (int k = 0; k < 102; k++) begin
         in_valid = (k < 100);
         b        = 32'(k);
         #1;
         if (k < 100) begin
            n_chk++;
            if (in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL stream_ready k=%0d got %b exp 1", k, in_ready);
            end
         end
         cyc();
         e = 32'(4 + k);
         n_chk++;
         if (k == 0 || k == 101) begin
            if (out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL stream_edge k=%0d got out_valid=%b exp 0", k, out_valid);
            end
         end else if (out_valid !== 1'b1 || out !== e) begin
            n_fail++;
            $display("FAIL stream k=%0d got v=%b out=%0d exp v=1 out=%0d",
                     k, out_valid, out, e);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_flags();
      logic [1:0]  ops [5];
      logic [31:0] av  [5];
      logic [31:0] bv  [5];
      logic [33:0] en  [5];
      logic [33:0] es  [5];
      logic        got;
      logic [33:0] rn, rs;
      ops = '{SUB, ADD, SUB, ADD, ADD};
      av  = '{32'd3, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
      bv  = '{32'd5, 32'd1, 32'd1, 32'd1, 32'h80000000};
      en  = '{{32'hFFFFFFFE, 2'b10}, {32'h80000000, 2'b01},
              {32'h7FFFFFFF, 2'b01}, {32'h00000000, 2'b10},
              {32'h00000000, 2'b11}};
      es  = '{{32'hFFFFFFFE, 2'b10}, {32'h7FFFFFFF, 2'b01},
              {32'h80000000, 2'b01}, {32'h00000000, 2'b10},
              {32'h80000000, 2'b11}};
      drain();
      for (int i = 0; i < 5; i++) begin
         send_one(ops[i], av[i], bv[i], got, rn, rs);
         n_chk++;
         if (!got || rn !== en[i]) begin
            n_fail++;
            $display("FAIL flags_%0d got=%b {out,c,o}=%h exp %h", i, got, rn, en[i]);
         end
         n_chk++;
         if (!got || rs !== es[i]) begin
            n_fail++;
            $display("FAIL flags_sat_%0d got=%b {out,c,o}=%h exp %h", i, got, rs, es[i]);
         end
      end
   endtask

   task automatic test_back_to_back_acc();
      logic [1:0]  ops [5];
      logic [31:0] av  [5];
      logic [31:0] ev  [5];
      ops = '{CLR, ACC, ACC, ACC, CLR};
      av  = '{32'd99, 32'd10, 32'd20, 32'd30, 32'd77};
      ev  = '{32'd0, 32'd10, 32'd30, 32'd60, 32'd0};
      drain();
      b = 32'd12345;
      for (int k = 0; k < 7; k++) begin
         in_valid = (k < 5);
         if (k < 5) begin
            in_op = ops[k];
            a     = av[k];
         end
         cyc();
         if (k >= 1 && k <= 5) begin
            n_chk++;
            if ({out_valid, out, out_carry, out_ovf} !== {1'b1, ev[k-1], 2'b00} ||
                s_out !== ev[k-1]) begin
               n_fail++;
               $display("FAIL acc_b2b_%0d got v=%b out=%0d sat=%0d c=%b o=%b exp %0d",
                        k - 1, out_valid, out, s_out, out_carry, out_ovf, ev[k-1]);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_acc_sat();
      logic        got;
      logic [33:0] rn, rs;
      drain();
      send_one(CLR, 32'd0, 32'd0, got, rn, rs);
      send_one(ACC, 32'h7FFFFFFF, 32'd0, got, rn, rs);
      send_one(ACC, 32'd1, 32'd0, got, rn, rs);
      n_chk++;
      if (!got || rn !== {32'h80000000, 2'b01} || rs !== {32'h7FFFFFFF, 2'b01}) begin
         n_fail++;
         $display("FAIL acc_ovf got=%b wrap=%h sat=%h exp %h/%h", got, rn, rs,
                  {32'h80000000, 2'b01}, {32'h7FFFFFFF, 2'b01});
      end
      send_one(ACC, 32'd1, 32'd0, got, rn, rs);
      n_chk++;
      if (!got || rn !== {32'h80000001, 2'b00} || rs !== {32'h7FFFFFFF, 2'b01}) begin
         n_fail++;
         $display("FAIL acc_stored got=%b wrap=%h sat=%h exp %h/%h", got, rn, rs,
                  {32'h80000001, 2'b00}, {32'h7FFFFFFF, 2'b01});
      end
   endtask

   task automatic test_stall();
      logic [31:0] q[$];
      logic [31:0] held;
      logic [31:0] e;
      int sent;
      int recv;
      drain();
      sent = 0;
      recv = 0;
      held = '0;
      in_op = ADD;
      for (int t = 0; t < 40 && recv < 8; t++) begin
         out_ready = !(t >= 4 && t < 7);
         in_valid  = (sent < 8);
         a         = 32'(1000 + sent);
         b         = 32'(sent);
         #1;
         if (t == 4) held = out;
         if (t >= 4 && t < 7) begin
            n_chk++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== held) begin
               n_fail++;
               $display("FAIL stall_hold t=%0d got rdy=%b v=%b out=%0d exp rdy=0 v=1 out=%0d",
                        t, in_ready, out_valid, out, held);
            end
         end
         if (out_valid && out_ready) begin
            n_chk++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL stall_extra got out=%0d exp no beat", out);
            end else begin
               e = q.pop_front();
               if (out !== e) begin
                  n_fail++;
                  $display("FAIL stall_data got %0d exp %0d", out, e);
               end
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            q.push_back(32'(1000 + 2 * sent));
            sent++;
         end
         cyc();
      end
      in_valid = 1'b0;
      n_chk++;
      if (recv != 8 || sent != 8 || q.size() != 0) begin
         n_fail++;
         $display("FAIL stall_count got sent=%0d recv=%0d left=%0d exp 8/8/0",
                  sent, recv, q.size());
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_flight();
      logic        seen;
      logic        got;
      logic [33:0] rn, rs;
      drain();
      out_ready = 1'b0;
      in_op     = ACC;
      a         = 32'd50;
      in_valid  = 1'b1;
      cyc();
      a = 32'd60;
      cyc();
      in_valid = 1'b0;
      n_chk++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL flight_setup got out_valid=%b exp 1", out_valid);
      end
      rst_n = 1'b0;
      cyc();
      n_chk++;
      if ({out_valid, in_ready, out, out_carry, out_ovf} !== 36'd0) begin
         n_fail++;
         $display("FAIL flight_reset got v=%b rdy=%b out=%h exp all 0",
                  out_valid, in_ready, out);
      end
      rst_n     = 1'b1;
      out_ready = 1'b1;
      seen      = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         if (out_valid) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL flight_discard got stale beat exp none");
      end
      send_one(ACC, 32'd7, 32'd0, got, rn, rs);
      n_chk++;
      if (!got || rn !== {32'd7, 2'b00} || rs !== {32'd7, 2'b00}) begin
         n_fail++;
         $display("FAIL flight_acc_zero got=%b wrap=%h sat=%h exp %h",
                  got, rn, rs, {32'd7, 2'b00});
      end
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_op     = ADD;
      a         = 32'd1;
      b         = 32'd2;
      out_ready = 1'b1;
      cyc();
      cyc();
      test_reset();
      test_stream();
      test_flags();
      test_back_to_back_acc();
      test_acc_sat();
      test_stall();
      test_reset_flight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
